// File: rtl/md_sequencer.sv
// HI/LO owner and multi-cycle multiply/divide sequencer; optional abort port under MD_CANCEL_EN.
// Latency: mult/div results land N edges after the start edge; mthi/mtlo land on the next edge.
// Backpressure: none accepted; md_stall holds D-stage MD instructions while an op is in flight.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_e,
  input  logic [2:0]  mdop_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_use_d,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_req_t     req;
  logic [3:0]  count;
  logic        do_cancel;

  logic [63:0] a_ext, b_ext, prod;
  logic        div_signed, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;
  logic [31:0] res_hi, res_lo;

`ifdef MD_CANCEL_EN
  assign do_cancel = cancel;
`else
  assign do_cancel = 1'b0;
`endif

  assign busy     = (count != 4'd0);
  assign md_stall = md_use_d & (busy | (start_e & ~mdop_e[2]));

  // Low 64 bits of a two's-complement product are exact once operands are extended to 64.
  always_comb begin
    a_ext = {32'b0, req.a};
    b_ext = {32'b0, req.b};
    if (!req.op[0]) begin
      a_ext = {{32{req.a[31]}}, req.a};
      b_ext = {{32{req.b[31]}}, req.b};
    end
    prod = a_ext * b_ext;
  end

  // Signed divide runs on magnitudes, then quotient/remainder signs are restored.
  always_comb begin
    div_signed = (req.op == 2'd2);
    div_zero   = (req.b == 32'd0);
    a_mag      = (div_signed && req.a[31]) ? -req.a : req.a;
    b_mag      = (div_signed && req.b[31]) ? -req.b : req.b;
    b_safe     = div_zero ? 32'd1 : b_mag;
    uq         = a_mag / b_safe;
    ur         = a_mag % b_safe;
    quot       = (div_signed && (req.a[31] ^ req.b[31])) ? -uq : uq;
    rem        = (div_signed && req.a[31]) ? -ur : ur;
  end

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (req.op[1]) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      req   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (do_cancel) begin
      count <= '0;
    end else if (busy) begin
      count <= count - 4'd1;
      if (count == 4'd1 && !(req.op[1] && div_zero)) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (start_e) begin
      case (mdop_e)
        3'd0, 3'd1: begin
          req   <= '{op: mdop_e[1:0], a: rs_e, b: rt_e};
          count <= MULT_LOAD;
        end
        3'd2, 3'd3: begin
          req   <= '{op: mdop_e[1:0], a: rs_e, b: rt_e};
          count <= DIV_LOAD;
        end
        3'd4:    hi <= rs_e;
        3'd5:    lo <= rs_e;
        default: ;
      endcase
    end
  end

endmodule
